free_list: RTL and testbench

Circular-FIFO free list of physical registers that feeds the rename unit's allocate interface (`alloc_valid`/`alloc_phys`) and absorbs its free-list return (`free_en`/`free_phys`). It keeps a speculative allocation head and a commit head, so a pipeline flush returns every uncommitted allocation in one cycle. A sticky error flag and a membership bitmap catch protocol violations: double free, freeing phys 0, overflow, and allocating from an empty list.

---
 rtl/rename_pkg.sv | 40 ++++
 rtl/free_list_if.sv | 29 ++
 rtl/free_list.sv | 158 +++++++++++++++
 tb/tb_free_list.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared rename-stage package.
// Holds the physical/architectural register counts and the tag and pointer
// types. The free list and the rename unit both import it, so tag widths
// cannot drift apart.
package rename_pkg;

    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;
    localparam int PHYS_W   = $clog2(NUM_PHYS);

    // Physical register tag.
    typedef logic [PHYS_W-1:0] phys_t;

    // Free-list pointer. The extra MSB is a wrap bit, so full and empty
    // are distinct with NUM_PHYS storage entries.
    typedef logic [PHYS_W:0] fl_ptr_t;

    // Events decoded from one cycle of handshake inputs. The *_ok bits
    // change state. The *_bad bits only feed the sticky error flag.
    typedef struct packed {
        logic alloc_ok;
        logic alloc_bad;
        logic commit_ok;
        logic commit_bad;
        logic free_ok;
        logic free_bad;
    } fl_evt_t;

    // Storage index addressed by a pointer (the wrap bit dropped).
    function automatic phys_t ptr_idx(input fl_ptr_t p);
        return p[PHYS_W-1:0];
    endfunction

    // Occupancy from 'from' up to 'to'. The subtraction is modulo
    // 2^(PHYS_W+1), which makes the wrap bit work out.
    function automatic fl_ptr_t ptr_dist(input fl_ptr_t from, input fl_ptr_t to);
        return fl_ptr_t'(to - from);
    endfunction

endpackage

// File: rtl/free_list_if.sv
// Free-list handshake bundle between the rename unit and the free list.
//   master (rename unit): drives alloc_req, commit_alloc, free_en,
//                         free_phys and flush. Observes alloc_valid,
//                         alloc_phys, free_count and err.
//   slave  (free list)  : the mirror image.
interface free_list_if;
    import rename_pkg::*;

    logic    alloc_req;
    logic    alloc_valid;
    phys_t   alloc_phys;
    logic    commit_alloc;
    logic    free_en;
    phys_t   free_phys;
    logic    flush;
    fl_ptr_t free_count;
    logic    err;

    modport master (
        output alloc_req, commit_alloc, free_en, free_phys, flush,
        input  alloc_valid, alloc_phys, free_count, err
    );

    modport slave (
        input  alloc_req, commit_alloc, free_en, free_phys, flush,
        output alloc_valid, alloc_phys, free_count, err
    );

endinterface

// File: rtl/free_list.sv
// free_list: circular-FIFO free list of physical registers for rename.
//
// Ports:
//   clk  - single clock domain
//   rst  - synchronous, active-high reset. It restores the full reset image.
//   fl   - free_list_if.slave:
//            alloc_req/alloc_valid/alloc_phys : speculative allocation at head
//            commit_alloc                     : retire oldest allocation (chead)
//            free_en/free_phys                : return a tag at tail
//            flush                            : head <- chead (squash)
//            free_count                       : tail - head
//            err                              : sticky protocol-violation flag
//
// Three pointers walk the ring:
//   chead .. head : tags handed to decode but not yet committed
//   head  .. tail : tags available for allocation
// A flush moves head back onto chead, so every uncommitted tag is
// reissued in its original order. in_list marks every tag between chead
// and tail. That covers uncommitted allocations too, so a double free is
// caught even while the tag is still in flight.
module free_list
    import rename_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    free_list_if.slave fl
);

    localparam fl_ptr_t CAPACITY   = fl_ptr_t'(NUM_PHYS);
    localparam fl_ptr_t RESET_TAIL = fl_ptr_t'(NUM_PHYS - NUM_ARCH);
    // Tags NUM_ARCH..NUM_PHYS-1 start out free. Architectural tags
    // (phys 0 included) start out mapped.
    localparam logic [NUM_PHYS-1:0] RESET_IN_LIST =
        {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    phys_t               mem [NUM_PHYS];
    logic [NUM_PHYS-1:0] in_list;
    fl_ptr_t             head;
    fl_ptr_t             chead;
    fl_ptr_t             tail;
    logic                err;

    // ------------------------------------------------------------------
    // Derived values
    // ------------------------------------------------------------------
    fl_ptr_t             spec_cnt;     // tail - head
    fl_ptr_t             comm_cnt;     // tail - chead
    logic                alloc_valid;
    phys_t               commit_tag;   // tag leaving the list on commit
    fl_evt_t             evt;

    logic [NUM_PHYS-1:0] in_list_nxt;
    fl_ptr_t             head_nxt;
    fl_ptr_t             chead_nxt;
    fl_ptr_t             tail_nxt;

    assign spec_cnt    = ptr_dist(head, tail);
    assign comm_cnt    = ptr_dist(chead, tail);
    assign alloc_valid = (head != tail);
    assign commit_tag  = mem[ptr_idx(chead)];

    // The head entry is read straight from storage. Decode samples it in
    // the same cycle it raises alloc_req.
    assign fl.alloc_valid = alloc_valid;
    assign fl.alloc_phys  = mem[ptr_idx(head)];
    assign fl.free_count  = spec_cnt;
    assign fl.err         = err;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    always_comb begin
        evt = '0;

        // A flush discards a same-cycle alloc_req silently, even when the
        // list is empty. Those instructions are being squashed anyway.
        evt.alloc_ok  = fl.alloc_req &&  alloc_valid && !fl.flush;
        evt.alloc_bad = fl.alloc_req && !alloc_valid && !fl.flush;

        // Commit needs an outstanding allocation. This checks head before
        // any same-cycle alloc, so the new allocation cannot be committed
        // in the cycle that creates it.
        evt.commit_ok  = fl.commit_alloc && (chead != head);
        evt.commit_bad = fl.commit_alloc && (chead == head);

        // Free is judged against pre-edge state only. A tag cannot be
        // freed in the same cycle its commit clears in_list.
        evt.free_ok  = fl.free_en
                    && (fl.free_phys != '0)
                    && !in_list[fl.free_phys]
                    && (comm_cnt < CAPACITY);
        evt.free_bad = fl.free_en && !evt.free_ok;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        chead_nxt = chead + fl_ptr_t'(evt.commit_ok);
        tail_nxt  = tail  + fl_ptr_t'(evt.free_ok);

        // Flush rewinds to the post-commit chead. Everything it skips
        // past is still committed and must not be reissued.
        if (fl.flush) begin
            head_nxt = chead_nxt;
        end else begin
            head_nxt = head + fl_ptr_t'(evt.alloc_ok);
        end
    end

    // Clear and set never hit the same bit. A commit clears a bit that is
    // currently 1, and an accepted free needs its bit currently 0.
    always_comb begin
        in_list_nxt = in_list;
        if (evt.commit_ok) begin
            in_list_nxt[commit_tag] = 1'b0;
        end
        if (evt.free_ok) begin
            in_list_nxt[fl.free_phys] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            chead   <= '0;
            tail    <= RESET_TAIL;
            in_list <= RESET_IN_LIST;
            err     <= 1'b0;
        end else begin
            head    <= head_nxt;
            chead   <= chead_nxt;
            tail    <= tail_nxt;
            in_list <= in_list_nxt;
            err     <= err | evt.alloc_bad | evt.commit_bad | evt.free_bad;
        end
    end

    // The tail slot is never the slot being committed in the same cycle.
    // An accepted free needs comm_cnt < CAPACITY, and a commit needs
    // comm_cnt > 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                mem[i] <= (i < NUM_PHYS - NUM_ARCH) ? phys_t'(NUM_ARCH + i) : '0;
            end
        end else if (evt.free_ok) begin
            mem[ptr_idx(tail)] <= fl.free_phys;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list. The reference model is a queue of
// tags in ring order (chead..tail) plus a count of how many at the front
// have been handed out speculatively.
module tb_free_list;
    import rename_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    free_list_if bus();

    free_list dut (.clk(clk), .rst(rst), .fl(bus));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    int q[$];        // tags from chead to tail, oldest first
    int so;          // leading entries of q already allocated (uncommitted)
    bit m_err;

    function automatic void model_reset();
        q = {};
        for (int i = 0; i < NUM_PHYS - NUM_ARCH; i++) q.push_back(NUM_ARCH + i);
        so    = 0;
        m_err = 0;
    endfunction

    function automatic bit model_has(input int t);
        foreach (q[k]) if (q[k] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_valid();
        return so < q.size();
    endfunction

    function automatic int exp_phys();
        return q[so];
    endfunction

    function automatic int exp_count();
        return q.size() - so;
    endfunction

    function automatic void model_step(input bit a, input bit c, input bit fe,
                                       input int ft, input bit fl);
        bit valid, aok, aerr, cok, cerr, fok, ferr;
        valid = exp_valid();
        aok   = a && valid && !fl;
        aerr  = a && !valid && !fl;
        cok   = c && (so > 0);
        cerr  = c && !cok;
        fok   = fe && (ft != 0) && !model_has(ft) && (q.size() < NUM_PHYS);
        ferr  = fe && !fok;
        if (cok) begin
            void'(q.pop_front());
            so--;
        end
        if (aok) so++;
        if (fl) so = 0;
        if (fok) q.push_back(ft);
        m_err = m_err | aerr | cerr | ferr;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus.alloc_req    = 1'b0;
        bus.commit_alloc = 1'b0;
        bus.free_en      = 1'b0;
        bus.free_phys    = '0;
        bus.flush        = 1'b0;
    endtask

    task automatic cycle(input bit a, input bit c, input bit fe, input int ft, input bit fl);
        bus.alloc_req    = a;
        bus.commit_alloc = c;
        bus.free_en      = fe;
        bus.free_phys    = phys_t'(ft);
        bus.flush        = fl;
        model_step(a, c, fe, ft, fl);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (bus.alloc_valid !== 1'b1) begin failures++; $display("FAIL reset_valid got=%0b want=1", bus.alloc_valid); end
        checks++; if (bus.alloc_phys !== phys_t'(32)) begin failures++; $display("FAIL reset_phys got=%0d want=32", bus.alloc_phys); end
        checks++; if (bus.free_count !== fl_ptr_t'(32)) begin failures++; $display("FAIL reset_count got=%0d want=32", bus.free_count); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", bus.err); end
    endtask

    task automatic test_drain_and_empty();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (bus.alloc_valid !== 1'b1 || bus.alloc_phys !== phys_t'(32 + i)) begin
                failures++;
                $display("FAIL drain_%0d got=%0b/%0d want=1/%0d", i, bus.alloc_valid, bus.alloc_phys, 32 + i);
            end
            cycle(1, 0, 0, 0, 0);
        end
        checks++; if (bus.alloc_valid !== 1'b0) begin failures++; $display("FAIL empty_valid got=%0b want=0", bus.alloc_valid); end
        checks++; if (bus.free_count !== fl_ptr_t'(0)) begin failures++; $display("FAIL empty_count got=%0d want=0", bus.free_count); end
        // 33rd allocation from an empty list
        cycle(1, 0, 0, 0, 0);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL empty_alloc_err got=%0b want=1", bus.err); end
        checks++; if (bus.free_count !== fl_ptr_t'(0)) begin failures++; $display("FAIL empty_alloc_count got=%0d want=0", bus.free_count); end
        // retire all 32 so tag 40 may legally come back
        for (int i = 0; i < 32; i++) cycle(0, 1, 0, 0, 0);
        // free 40 into the empty list: no bypass in the same cycle
        bus.free_en   = 1'b1;
        bus.free_phys = phys_t'(40);
        model_step(0, 0, 1, 40, 0);
        checks++; if (bus.alloc_valid !== 1'b0) begin failures++; $display("FAIL nobypass_valid got=%0b want=0", bus.alloc_valid); end
        @(posedge clk);
        #1;
        idle_inputs();
        checks++;
        if (bus.alloc_valid !== 1'b1 || bus.alloc_phys !== phys_t'(40)) begin
            failures++;
            $display("FAIL refill got=%0b/%0d want=1/40", bus.alloc_valid, bus.alloc_phys);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        checks++; if (bus.alloc_phys !== phys_t'(34)) begin failures++; $display("FAIL flush_phys got=%0d want=34", bus.alloc_phys); end
        checks++; if (bus.free_count !== fl_ptr_t'(30)) begin failures++; $display("FAIL flush_count got=%0d want=30", bus.free_count); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.alloc_phys !== phys_t'(34 + i)) begin
                failures++;
                $display("FAIL reissue_%0d got=%0d want=%0d", i, bus.alloc_phys, 34 + i);
            end
            cycle(1, 0, 0, 0, 0);
        end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL flush_err got=%0b want=0", bus.err); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 7, 0);
        checks++; if (bus.free_count !== fl_ptr_t'(31)) begin failures++; $display("FAIL simul_count got=%0d want=31", bus.free_count); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL simul_err got=%0b want=0", bus.err); end
        checks++; if (bus.alloc_phys !== phys_t'(34)) begin failures++; $display("FAIL simul_phys got=%0d want=34", bus.alloc_phys); end
        // drain 34..63; tag 7 must then sit at the head (tail moved)
        for (int i = 0; i < 30; i++) cycle(1, 0, 0, 0, 0);
        checks++;
        if (bus.alloc_valid !== 1'b1 || bus.alloc_phys !== phys_t'(7)) begin
            failures++;
            $display("FAIL simul_tail got=%0b/%0d want=1/7", bus.alloc_valid, bus.alloc_phys);
        end
    endtask

    task automatic test_violations();
        do_reset();
        cycle(0, 0, 1, 0, 0);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL free0_err got=%0b want=1", bus.err); end
        checks++; if (bus.free_count !== fl_ptr_t'(32)) begin failures++; $display("FAIL free0_count got=%0d want=32", bus.free_count); end

        do_reset();
        cycle(0, 0, 1, 33, 0);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL dblfree_err got=%0b want=1", bus.err); end
        checks++; if (bus.free_count !== fl_ptr_t'(32)) begin failures++; $display("FAIL dblfree_count got=%0d want=32", bus.free_count); end

        do_reset();
        cycle(0, 1, 0, 0, 0);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL badcommit_err got=%0b want=1", bus.err); end
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 1, 5, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL sticky_err got=%0b want=1", bus.err); end
        do_reset();
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%0b want=0", bus.err); end
    endtask

    task automatic test_wrap_and_reset();
        int amap[NUM_ARCH];
        int r, t;
        do_reset();
        for (int i = 0; i < NUM_ARCH; i++) amap[i] = i;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(NUM_ARCH - 1, 1);
            checks++;
            if (bus.alloc_valid !== 1'b1 || bus.alloc_phys !== phys_t'(exp_phys())) begin
                failures++;
                $display("FAIL wrap_alloc_%0d got=%0b/%0d want=1/%0d", n, bus.alloc_valid, bus.alloc_phys, exp_phys());
            end
            t = exp_phys();
            cycle(1, 0, 0, 0, 0);
            if ($urandom_range(3, 0) == 0) cycle(0, 0, 0, 0, 0);
            cycle(0, 1, 1, amap[r], 0);
            amap[r] = t;
        end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL wrap_err got=%0b want=0", bus.err); end
        checks++; if (bus.free_count !== fl_ptr_t'(32)) begin failures++; $display("FAIL wrap_count got=%0d want=32", bus.free_count); end

        // leave some state in flight, then reset with every input busy
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        bus.alloc_req    = 1'b1;
        bus.commit_alloc = 1'b1;
        bus.free_en      = 1'b1;
        bus.free_phys    = phys_t'(5);
        bus.flush        = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        model_reset();
        checks++;
        if (bus.alloc_valid !== 1'b1 || bus.alloc_phys !== phys_t'(32) ||
            bus.free_count !== fl_ptr_t'(32) || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL midreset got=%0b/%0d/%0d/%0b want=1/32/32/0",
                     bus.alloc_valid, bus.alloc_phys, bus.free_count, bus.err);
        end
    endtask

    task automatic test_random();
        bit a, c, fe, fl;
        int ft;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            checks++;
            if (bus.alloc_valid !== exp_valid() ||
                (exp_valid() && bus.alloc_phys !== phys_t'(exp_phys())) ||
                bus.free_count !== fl_ptr_t'(exp_count()) ||
                bus.err !== m_err) begin
                failures++;
                $display("FAIL rand_%0d got=%0b/%0d/%0d/%0b want=%0b/%0d/%0d/%0b", n,
                         bus.alloc_valid, bus.alloc_phys, bus.free_count, bus.err,
                         exp_valid(), exp_valid() ? exp_phys() : 0, exp_count(), m_err);
            end
            a  = ($urandom_range(1, 0) == 1);
            c  = ($urandom_range(2, 0) == 0);
            fe = ($urandom_range(2, 0) == 0);
            fl = ($urandom_range(19, 0) == 0);
            ft = $urandom_range(NUM_PHYS - 1, 0);
            cycle(a, c, fe, ft, fl);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_drain_and_empty();
        test_flush();
        test_simultaneous();
        test_violations();
        test_wrap_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
